// File: rtl/axi_grid_sni_pkg.sv
// Shared types for the subordinate-side grid network interface.
// Purpose: AXI channel payloads seen by the local manager, the request/response
//          bundles exchanged with it, and the grid flit formats that wrap each
//          AXI payload with a {src, dst} node-id header.
// Ports:   none (package).
package axi_grid_sni_pkg;

    localparam int unsigned ID_W     = 4;   // grid node id width
    localparam int unsigned AXI_ID_W = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LEN_W    = 8;

    typedef logic [ID_W-1:0] grid_id_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
    } axi_ax_t;

    typedef axi_ax_t axi_aw_t;
    typedef axi_ax_t axi_ar_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
        logic [1:0]          resp;
        logic                last;
    } axi_r_t;

    // Manager -> NI
    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } sni_req_t;

    // NI -> manager
    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } sni_resp_t;

    typedef struct packed { grid_id_t src; grid_id_t dst; axi_aw_t payload; } grid_aw_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; axi_w_t  payload; } grid_w_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; axi_b_t  payload; } grid_b_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; axi_ar_t payload; } grid_ar_chan_t;
    typedef struct packed { grid_id_t src; grid_id_t dst; axi_r_t  payload; } grid_r_chan_t;

endpackage

// File: rtl/axi_grid_sni_dst_fifo.sv
// Synchronous FIFO of grid node ids. Holds the destination of every accepted
// AW so the matching W burst can be routed to the same node.
// Ports:
//   i_clk, i_arst_n      clock, asynchronous active-low reset (FIFO empties)
//   i_push, i_data       enqueue one id
//   i_pop                dequeue the head
//   o_data               current head (valid while !o_empty)
//   o_full, o_empty      occupancy flags
// DEPTH must be a power of two and at least 2.
module axi_grid_sni_dst_fifo
    import axi_grid_sni_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_arst_n,
    input  logic     i_push,
    input  grid_id_t i_data,
    input  logic     i_pop,
    output grid_id_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    grid_id_t      r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
            if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed while non-empty.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/axi_grid_sni.sv
// Subordinate-side grid network interface.
// Purpose: accepts AXI requests from a local manager, packetises AW/W/AR onto
//          grid channels tagged {src=NI_ID, dst=addr decode}, and returns grid
//          B/R flits to the manager with the header stripped.
// Ports:
//   clk_i, arst_ni                      clock, async active-low reset
//   req_i / resp_o                      AXI bundle from / to the manager
//   grid_{aw,w,ar}_o/_valid_o/_ready_i  outgoing request flits
//   grid_{b,r}_i/_valid_i/_ready_o      incoming response flits
// Responses from different destinations could come back out of order, so each
// direction only issues to a new destination once everything in flight has
// retired; consecutive transactions to the same destination stream freely up
// to MAX_OUTST.
module axi_grid_sni
    import axi_grid_sni_pkg::*;
#(
    parameter grid_id_t    NI_ID        = '0,
    parameter int unsigned DST_ADDR_LSB = 28,
    parameter int unsigned MAX_OUTST    = 8,
    parameter int unsigned W_FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  sni_req_t      req_i,
    output sni_resp_t     resp_o,
    output grid_aw_chan_t grid_aw_o,
    output logic          grid_aw_valid_o,
    input  logic          grid_aw_ready_i,
    output grid_w_chan_t  grid_w_o,
    output logic          grid_w_valid_o,
    input  logic          grid_w_ready_i,
    output grid_ar_chan_t grid_ar_o,
    output logic          grid_ar_valid_o,
    input  logic          grid_ar_ready_i,
    input  grid_b_chan_t  grid_b_i,
    input  logic          grid_b_valid_i,
    output logic          grid_b_ready_o,
    input  grid_r_chan_t  grid_r_i,
    input  logic          grid_r_valid_i,
    output logic          grid_r_ready_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    // Issue is allowed when nothing is in flight, or when staying on the same
    // destination with room left in the outstanding budget.
    function automatic logic guard_ok(input logic [CNT_W-1:0] cnt,
                                      input grid_id_t         cur_dst,
                                      input grid_id_t         dec_dst);
        return (cnt == '0) || ((dec_dst == cur_dst) && (cnt < CNT_W'(MAX_OUTST)));
    endfunction

    // r_en releases synchronously one edge after reset deasserts; every
    // valid/ready output is gated by it, so no handshake (and thus no state
    // change) can occur while reset is asserted or during its release.
    logic r_en;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) r_en <= 1'b0;
        else          r_en <= 1'b1;
    end

    logic [CNT_W-1:0] r_aw_cnt;
    logic [CNT_W-1:0] r_ar_cnt;
    grid_id_t         r_aw_dst;
    grid_id_t         r_ar_dst;

    grid_id_t w_aw_dec;
    grid_id_t w_ar_dec;
    grid_id_t w_fifo_head;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_aw_ok;
    logic     w_ar_ok;
    logic     w_w_ok;
    logic     w_aw_hs;
    logic     w_w_hs;
    logic     w_ar_hs;
    logic     w_b_hs;
    logic     w_r_hs;
    logic     w_r_retire;
    logic     w_unused_rsp_hdr;

    assign w_aw_dec = req_i.aw.addr[DST_ADDR_LSB +: ID_W];
    assign w_ar_dec = req_i.ar.addr[DST_ADDR_LSB +: ID_W];

    // Readiness never looks at the manager's valid, only at internal state.
    assign w_aw_ok = r_en && guard_ok(r_aw_cnt, r_aw_dst, w_aw_dec) && !w_fifo_full;
    assign w_ar_ok = r_en && guard_ok(r_ar_cnt, r_ar_dst, w_ar_dec);
    assign w_w_ok  = r_en && !w_fifo_empty;

    assign grid_aw_valid_o = req_i.aw_valid && w_aw_ok;
    assign grid_w_valid_o  = req_i.w_valid  && w_w_ok;
    assign grid_ar_valid_o = req_i.ar_valid && w_ar_ok;
    assign grid_b_ready_o  = req_i.b_ready  && r_en;
    assign grid_r_ready_o  = req_i.r_ready  && r_en;

    assign grid_aw_o = '{src: NI_ID, dst: w_aw_dec,    payload: req_i.aw};
    assign grid_w_o  = '{src: NI_ID, dst: w_fifo_head, payload: req_i.w};
    assign grid_ar_o = '{src: NI_ID, dst: w_ar_dec,    payload: req_i.ar};

    assign w_aw_hs    = grid_aw_valid_o && grid_aw_ready_i;
    assign w_w_hs     = grid_w_valid_o  && grid_w_ready_i;
    assign w_ar_hs    = grid_ar_valid_o && grid_ar_ready_i;
    assign w_b_hs     = grid_b_valid_i  && grid_b_ready_o;
    assign w_r_hs     = grid_r_valid_i  && grid_r_ready_o;
    assign w_r_retire = w_r_hs && grid_r_i.payload.last;

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = grid_aw_ready_i && w_aw_ok;
        resp_o.w_ready  = grid_w_ready_i  && w_w_ok;
        resp_o.ar_ready = grid_ar_ready_i && w_ar_ok;
        resp_o.b        = grid_b_i.payload;
        resp_o.b_valid  = grid_b_valid_i && r_en;
        resp_o.r        = grid_r_i.payload;
        resp_o.r_valid  = grid_r_valid_i && r_en;
    end

    // Response headers are consumed by the grid; the manager never sees them.
    assign w_unused_rsp_hdr = ^{grid_b_i.src, grid_b_i.dst, grid_r_i.src, grid_r_i.dst};

    // Write-direction guard: issue and retire in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_aw_cnt <= '0;
            r_aw_dst <= '0;
        end else begin
            if (w_aw_hs && !w_b_hs)      r_aw_cnt <= r_aw_cnt + CNT_W'(1);
            else if (!w_aw_hs && w_b_hs) r_aw_cnt <= r_aw_cnt - CNT_W'(1);
            if (w_aw_hs) r_aw_dst <= w_aw_dec;
        end
    end

    // Read-direction guard: a burst retires on its last beat.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ar_cnt <= '0;
            r_ar_dst <= '0;
        end else begin
            if (w_ar_hs && !w_r_retire)      r_ar_cnt <= r_ar_cnt + CNT_W'(1);
            else if (!w_ar_hs && w_r_retire) r_ar_cnt <= r_ar_cnt - CNT_W'(1);
            if (w_ar_hs) r_ar_dst <= w_ar_dec;
        end
    end

    // W bursts follow AW order; the FIFO holds each accepted AW's destination
    // until its burst's last beat is accepted. No push-through when empty.
    axi_grid_sni_dst_fifo #(
        .DEPTH (W_FIFO_DEPTH)
    ) u_dst_fifo (
        .i_clk    (clk_i),
        .i_arst_n (arst_ni),
        .i_push   (w_aw_hs),
        .i_data   (w_aw_dec),
        .i_pop    (w_w_hs && req_i.w.last),
        .o_data   (w_fifo_head),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

endmodule

// File: tb/tb_axi_grid_sni.sv
module tb_axi_grid_sni;
    import axi_grid_sni_pkg::*;

    localparam grid_id_t    NI      = 4'd1;
    localparam int unsigned MAXO    = 8;
    localparam int unsigned WDEPTH  = 4;

    logic          clk = 1'b0;
    logic          arst_ni;
    sni_req_t      req;
    sni_resp_t     resp;
    grid_aw_chan_t grid_aw_o;
    grid_w_chan_t  grid_w_o;
    grid_ar_chan_t grid_ar_o;
    grid_b_chan_t  grid_b_i;
    grid_r_chan_t  grid_r_i;
    logic grid_aw_valid_o, grid_aw_ready_i;
    logic grid_w_valid_o,  grid_w_ready_i;
    logic grid_ar_valid_o, grid_ar_ready_i;
    logic grid_b_valid_i,  grid_b_ready_o;
    logic grid_r_valid_i,  grid_r_ready_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model: destinations of in-flight transactions per direction
    // and destinations of W bursts still owed, in AW order.
    grid_id_t wr_out[$];
    grid_id_t rd_out[$];
    grid_id_t wq[$];
    bit       m_en = 1'b0;
    bit       hs_aw, hs_w, hs_ar, hs_b, hs_r;

    // Manager-side bookkeeping for the random phase.
    logic [7:0] wlen_q[$];
    int         wbeat = 0;

    always #5 clk = ~clk;

    axi_grid_sni #(
        .NI_ID        (NI),
        .DST_ADDR_LSB (28),
        .MAX_OUTST    (MAXO),
        .W_FIFO_DEPTH (WDEPTH)
    ) dut (
        .clk_i           (clk),
        .arst_ni         (arst_ni),
        .req_i           (req),
        .resp_o          (resp),
        .grid_aw_o       (grid_aw_o),
        .grid_aw_valid_o (grid_aw_valid_o),
        .grid_aw_ready_i (grid_aw_ready_i),
        .grid_w_o        (grid_w_o),
        .grid_w_valid_o  (grid_w_valid_o),
        .grid_w_ready_i  (grid_w_ready_i),
        .grid_ar_o       (grid_ar_o),
        .grid_ar_valid_o (grid_ar_valid_o),
        .grid_ar_ready_i (grid_ar_ready_i),
        .grid_b_i        (grid_b_i),
        .grid_b_valid_i  (grid_b_valid_i),
        .grid_b_ready_o  (grid_b_ready_o),
        .grid_r_i        (grid_r_i),
        .grid_r_valid_i  (grid_r_valid_i),
        .grid_r_ready_o  (grid_r_ready_o)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // A transaction may go out when nothing is in flight, or when every
    // in-flight one targets the same node and the budget is not exhausted.
    function automatic bit issue_ok(input grid_id_t q[$], input grid_id_t d);
        if (q.size() == 0) return 1'b1;
        if (q.size() >= MAXO) return 1'b0;
        foreach (q[i]) if (q[i] != d) return 1'b0;
        return 1'b1;
    endfunction

    // Compare process: checks every output each cycle, then advances the model.
    always @(negedge clk) begin : cmp
        grid_id_t awd, ard;
        bit aw_ok, ar_ok, w_ok;
        if (!arst_ni) begin
            wr_out.delete(); rd_out.delete(); wq.delete();
            m_en = 1'b0;
            {hs_aw, hs_w, hs_ar, hs_b, hs_r} = '0;
            chk("rst_aw_valid", grid_aw_valid_o, 0);
            chk("rst_aw_ready", resp.aw_ready, 0);
            chk("rst_w_valid",  grid_w_valid_o, 0);
            chk("rst_w_ready",  resp.w_ready, 0);
            chk("rst_ar_valid", grid_ar_valid_o, 0);
            chk("rst_ar_ready", resp.ar_ready, 0);
            chk("rst_b_valid",  resp.b_valid, 0);
            chk("rst_b_ready",  grid_b_ready_o, 0);
            chk("rst_r_valid",  resp.r_valid, 0);
            chk("rst_r_ready",  grid_r_ready_o, 0);
        end else begin
            awd   = req.aw.addr[31:28];
            ard   = req.ar.addr[31:28];
            aw_ok = m_en && issue_ok(wr_out, awd) && (wq.size() < WDEPTH);
            ar_ok = m_en && issue_ok(rd_out, ard);
            w_ok  = m_en && (wq.size() > 0);

            chk("aw_valid", grid_aw_valid_o, req.aw_valid && aw_ok);
            chk("aw_ready", resp.aw_ready, grid_aw_ready_i && aw_ok);
            chk("w_valid",  grid_w_valid_o, req.w_valid && w_ok);
            chk("w_ready",  resp.w_ready, grid_w_ready_i && w_ok);
            chk("ar_valid", grid_ar_valid_o, req.ar_valid && ar_ok);
            chk("ar_ready", resp.ar_ready, grid_ar_ready_i && ar_ok);
            chk("b_valid",  resp.b_valid, m_en && grid_b_valid_i);
            chk("b_ready",  grid_b_ready_o, m_en && req.b_ready);
            chk("r_valid",  resp.r_valid, m_en && grid_r_valid_i);
            chk("r_ready",  grid_r_ready_o, m_en && req.r_ready);
            if (req.aw_valid && aw_ok) chk("aw_flit", grid_aw_o, {NI, awd, req.aw});
            if (req.ar_valid && ar_ok) chk("ar_flit", grid_ar_o, {NI, ard, req.ar});
            if (req.w_valid && w_ok)   chk("w_flit",  grid_w_o,  {NI, wq[0], req.w});
            if (m_en && grid_b_valid_i) chk("b_payload", resp.b, grid_b_i.payload);
            if (m_en && grid_r_valid_i) chk("r_payload", resp.r, grid_r_i.payload);

            hs_aw = req.aw_valid && aw_ok && grid_aw_ready_i;
            hs_ar = req.ar_valid && ar_ok && grid_ar_ready_i;
            hs_w  = req.w_valid && w_ok && grid_w_ready_i;
            hs_b  = m_en && grid_b_valid_i && req.b_ready;
            hs_r  = m_en && grid_r_valid_i && req.r_ready;

            if (hs_b) void'(wr_out.pop_front());
            if (hs_w && req.w.last) void'(wq.pop_front());
            if (hs_aw) begin wr_out.push_back(awd); wq.push_back(awd); end
            if (hs_r && grid_r_i.payload.last) void'(rd_out.pop_front());
            if (hs_ar) rd_out.push_back(ard);
            m_en = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        req = '0;
        grid_aw_ready_i = 0; grid_w_ready_i = 0; grid_ar_ready_i = 0;
        grid_b_valid_i = 0;  grid_r_valid_i = 0;
        grid_b_i = '0;       grid_r_i = '0;
    endtask

    task automatic aw_issue(input logic [31:0] addr, input logic [7:0] len);
        req.aw = '{id: 4'h1, addr: addr, len: len};
        req.aw_valid = 1; grid_aw_ready_i = 1;
        step();
        req.aw_valid = 0;
    endtask

    task automatic ar_issue(input logic [31:0] addr);
        req.ar = '{id: 4'h2, addr: addr, len: 8'd0};
        req.ar_valid = 1; grid_ar_ready_i = 1;
        step();
        req.ar_valid = 0;
    endtask

    task automatic w_burst(input int len);
        for (int b = 0; b <= len; b++) begin
            req.w = '{data: 32'hA000 + b, strb: 4'hF, last: (b == len)};
            req.w_valid = 1; grid_w_ready_i = 1;
            step();
        end
        req.w_valid = 0;
    endtask

    task automatic b_ret();
        grid_b_i = '{src: 4'h3, dst: NI, payload: '{id: 4'h1, resp: 2'b00}};
        grid_b_valid_i = 1; req.b_ready = 1;
        step();
        grid_b_valid_i = 0;
    endtask

    task automatic r_ret();
        grid_r_i = '{src: 4'h2, dst: NI, payload: '{id: 4'h2, data: 32'h1234, resp: 2'b00, last: 1'b1}};
        grid_r_valid_i = 1; req.r_ready = 1;
        step();
        grid_r_valid_i = 0;
    endtask

    initial begin
        logic [3:0] t5_dst [5];
        t5_dst = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
        arst_ni = 0;
        clr();
        repeat (3) step();
        arst_ni = 1;
        step();
        step();

        // Write to dst 3, 4-beat burst, then B.
        req.aw = '{id: 4'h1, addr: 32'h3000_0040, len: 8'd3};
        req.aw_valid = 1; grid_aw_ready_i = 1;
        #2;
        chk("t1_aw_valid", grid_aw_valid_o, 1);
        chk("t1_aw_src", grid_aw_o.src, 1);
        chk("t1_aw_dst", grid_aw_o.dst, 3);
        step();
        req.aw_valid = 0;
        for (int b = 0; b < 4; b++) begin
            req.w = '{data: 32'h100 + b, strb: 4'hF, last: (b == 3)};
            req.w_valid = 1; grid_w_ready_i = 1;
            #2;
            chk("t1_w_valid", grid_w_valid_o, 1);
            chk("t1_w_dst", grid_w_o.dst, 3);
            chk("t1_w_last", grid_w_o.payload.last, (b == 3));
            step();
        end
        req.w_valid = 0;
        grid_b_i = '{src: 4'h3, dst: NI, payload: '{id: 4'h1, resp: 2'b00}};
        grid_b_valid_i = 1; req.b_ready = 1;
        #2;
        chk("t1_b_valid", resp.b_valid, 1);
        step();
        grid_b_valid_i = 0;
        // Counter back at 0: a different destination issues at once.
        req.aw = '{id: 4'h1, addr: 32'h5000_0000, len: 8'd0};
        req.aw_valid = 1;
        #2;
        chk("t1_cnt0_newdst", grid_aw_valid_o, 1);
        step();
        req.aw_valid = 0;
        w_burst(0);
        b_ret();

        // Read to dst 2, then dst 5 held until rlast returns.
        ar_issue(32'h2000_0000);
        req.ar = '{id: 4'h2, addr: 32'h5000_0000, len: 8'd0};
        req.ar_valid = 1; grid_ar_ready_i = 1;
        grid_r_i = '{src: 4'h2, dst: NI, payload: '{id: 4'h2, data: 32'h55, resp: 2'b00, last: 1'b1}};
        grid_r_valid_i = 1; req.r_ready = 1;
        #2;
        chk("t2_ar_held_valid", grid_ar_valid_o, 0);
        chk("t2_ar_held_ready", resp.ar_ready, 0);
        step();
        grid_r_valid_i = 0;
        #2;
        chk("t2_ar_issue", grid_ar_valid_o, 1);
        chk("t2_ar_dst", grid_ar_o.dst, 5);
        step();
        req.ar_valid = 0;
        r_ret();

        // Eight reads to dst 2 fill the budget; the ninth waits for one rlast.
        for (int i = 0; i < 8; i++) ar_issue(32'h2000_0000 + 32'(i * 64));
        req.ar = '{id: 4'h2, addr: 32'h2000_1000, len: 8'd0};
        req.ar_valid = 1;
        #2;
        chk("t3_ar9_stall", grid_ar_valid_o, 0);
        step();
        grid_r_i = '{src: 4'h2, dst: NI, payload: '{id: 4'h2, data: 32'h77, resp: 2'b00, last: 1'b1}};
        grid_r_valid_i = 1; req.r_ready = 1;
        #2;
        chk("t3_ar9_stall_r", grid_ar_valid_o, 0);
        step();
        grid_r_valid_i = 0;
        #2;
        chk("t3_ar9_issue", grid_ar_valid_o, 1);
        step();
        req.ar_valid = 0;
        repeat (8) r_ret();

        // Back-pressure on AW: flit stays put for 5 cycles.
        req.aw = '{id: 4'h6, addr: 32'h1000_0ABC, len: 8'd0};
        req.aw_valid = 1; grid_aw_ready_i = 0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("t4_aw_valid", grid_aw_valid_o, 1);
            chk("t4_aw_addr", grid_aw_o.payload.addr, 32'h1000_0ABC);
            chk("t4_aw_dst", grid_aw_o.dst, 1);
            step();
        end
        grid_aw_ready_i = 1;
        step();
        req.aw_valid = 0;
        w_burst(0);
        b_ret();

        // Four AWs queued with W withheld: fifth stalls, W follows AW order.
        for (int k = 0; k < 4; k++) begin
            aw_issue({t5_dst[k], 28'h0000100}, 8'd0);
            b_ret();
        end
        req.aw = '{id: 4'h1, addr: 32'h1000_0200, len: 8'd0};
        req.aw_valid = 1; grid_aw_ready_i = 1;
        #2;
        chk("t5_aw5_full", resp.aw_ready, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            req.w = '{data: 32'hB0 + k, strb: 4'hF, last: 1'b1};
            req.w_valid = 1; grid_w_ready_i = 1;
            #2;
            chk("t5_w_dst", grid_w_o.dst, t5_dst[k]);
            if (k == 1) chk("t5_aw5_issue", grid_aw_valid_o, 1);
            step();
            if (k == 1) req.aw_valid = 0;
        end
        req.w_valid = 0;
        b_ret();

        // Reset mid-burst after 2 of 4 beats.
        aw_issue(32'h3000_0000, 8'd3);
        for (int b = 0; b < 2; b++) begin
            req.w = '{data: 32'hC0 + b, strb: 4'hF, last: 1'b0};
            req.w_valid = 1; grid_w_ready_i = 1;
            step();
        end
        req.aw = '{id: 4'h1, addr: 32'h3000_0000, len: 8'd0};
        req.aw_valid = 1; grid_aw_ready_i = 1;
        arst_ni = 0;
        #2;
        chk("t6_rst_w_valid", grid_w_valid_o, 0);
        chk("t6_rst_aw_valid", grid_aw_valid_o, 0);
        step();
        clr();
        step();
        arst_ni = 1;
        step();
        req.w = '{data: 32'hD0, strb: 4'hF, last: 1'b1};
        req.w_valid = 1; grid_w_ready_i = 1;
        req.aw = '{id: 4'h1, addr: 32'h7000_0000, len: 8'd0};
        req.aw_valid = 1; grid_aw_ready_i = 1;
        #2;
        chk("t6_fifo_empty", grid_w_valid_o, 0);
        chk("t6_cnt0", grid_aw_valid_o, 1);
        step();
        req.aw_valid = 0;
        #2;
        chk("t6_fresh_w_dst", grid_w_o.dst, 7);
        step();
        req.w_valid = 0;
        b_ret();
        clr();
        repeat (2) step();

        // Randomised traffic from an AXI-compliant manager and grid.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                arst_ni = 0;
                clr();
                wlen_q.delete(); wbeat = 0;
                repeat (3) step();
                arst_ni = 1;
                step();
            end
            if (hs_aw) wlen_q.push_back(req.aw.len);
            if (!(req.aw_valid && !hs_aw)) begin
                req.aw_valid = ($urandom_range(2) == 0);
                req.aw.id    = 4'($urandom);
                req.aw.addr  = {4'($urandom_range(3, 1)), 28'($urandom)};
                req.aw.len   = 8'($urandom_range(3));
            end
            if (hs_w) begin
                if (req.w.last) begin void'(wlen_q.pop_front()); wbeat = 0; end
                else wbeat++;
            end
            if (!(req.w_valid && !hs_w)) begin
                if (wlen_q.size() > 0 && $urandom_range(1) == 1) begin
                    req.w_valid = 1;
                    req.w.data  = $urandom;
                    req.w.strb  = 4'($urandom);
                    req.w.last  = (wbeat == int'(wlen_q[0]));
                end else req.w_valid = 0;
            end
            if (!(req.ar_valid && !hs_ar)) begin
                req.ar_valid = ($urandom_range(1) == 0);
                req.ar.id    = 4'($urandom);
                req.ar.addr  = {(($urandom_range(3) == 0) ? 4'd5 : 4'd2), 28'($urandom)};
                req.ar.len   = 8'($urandom_range(3));
            end
            if (!(grid_b_valid_i && !hs_b)) begin
                grid_b_valid_i = (wr_out.size() > 0) && ($urandom_range(2) == 0);
                grid_b_i = '{src: 4'($urandom), dst: NI, payload: '{id: 4'($urandom), resp: 2'($urandom)}};
            end
            if (!(grid_r_valid_i && !hs_r)) begin
                grid_r_valid_i = (rd_out.size() > 0) && ($urandom_range(3) == 0);
                grid_r_i = '{src: 4'($urandom), dst: NI,
                             payload: '{id: 4'($urandom), data: $urandom, resp: 2'($urandom),
                                        last: 1'($urandom)}};
            end
            grid_aw_ready_i = ($urandom_range(3) != 0);
            grid_w_ready_i  = ($urandom_range(3) != 0);
            grid_ar_ready_i = ($urandom_range(3) != 0);
            req.b_ready     = ($urandom_range(2) != 0);
            req.r_ready     = ($urandom_range(2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
